vga_pattern_gen: RTL and testbench
==================================

Name: vga_pattern_gen

Overview:
- Parametrised VGA timing and test-pattern generator for TT tiles.
- Replaces fixed 640x480 timing with generic porch/sync/polarity parameters.
- Adds selectable patterns, a frame counter and optional scrolling.
- Drives the Tiny VGA PMOD pinout directly on uo_out; instantiated inside tt_um_* top modules.

Parameters:
H_VIS, 640, visible pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, hsync width
H_BP, 48, horizontal back porch
V_VIS, 480, visible lines
V_FP, 10, vertical front porch
V_SYNC, 2, vsync width
V_BP, 33, vertical back porch
H_POL, 0, hsync active level (0 = active-low)
V_POL, 0, vsync active level
CNT_W, 10, h/v counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clk  in  1  pixel clock
rst_n  in  1  reset
ena  in  1  tile enable; 0 freezes counters and outputs
osel  in  2  pattern select
color  in  6  RrGgBb colour for patterns 0/2
scroll  in  1  scroll request (used only with VGA_SCROLL_EN)
uo_out  out  8  {hsync,B0,G0,R0,vsync,B1,G1,R1} (bit7..bit0)
h_pos  out  CNT_W  current h counter
v_pos  out  CNT_W  current v counter
frame_start  out  1  one-cycle pulse at (h,v)=(0,0)
frame_cnt  out  8  frames completed, wraps 255->0

Behaviour:
- One clock (clk); reset rst_n is asynchronous and active-low.
- Totals:
  - H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP
  - V_TOTAL = V_VIS+V_FP+V_SYNC+V_BP
- Reset values:
  - h, v, frame_cnt = 0; frame_start = 0; colour latch = 0.
  - uo_out colour bits = 0; sync bits at inactive level (defaults give uo_out = 8'h88).
- Counters, when ena=1:
  - h increments each clock; at H_TOTAL-1, h wraps to 0 and v increments.
  - At v = V_TOTAL-1 with h wrap, v wraps to 0 and frame_cnt increments (mod 256).
  - ena=0 holds all state and all outputs.
- h_pos/v_pos show the counters directly.
- uo_out is registered from the current (h, v), so it lags h_pos/v_pos by exactly 1 clock.
- hsync is active when H_VIS+H_FP <= h < H_VIS+H_FP+H_SYNC; else inactive.
- vsync is active when V_VIS+V_FP <= v < V_VIS+V_FP+V_SYNC.
- Blanking: h >= H_VIS or v >= V_VIS forces rgb = 0. Sync is unaffected.
- frame_start is a registered pulse, high for the 1 clock in which uo_out shows pixel (0,0).
- Colour latch:
  - Samples color when h = H_TOTAL-1 and v = V_TOTAL-1, i.e. updates only at frame boundaries.
  - A mid-frame change of color never tears the image.
- Patterns, rgb = {R1,R0,G1,G0,B1,B0}, with x = h:
  - osel 0: rgb = latched colour.
  - osel 1: rgb = x[9:4] (16-pixel vertical bars); bits above CNT_W-1 read as 0.
  - osel 2: rgb = (x[3]^v[3]) ? latched colour : ~latched colour (8x8 checkerboard).
  - osel 3: rgb = frame_cnt[5:0] (full-screen flash).
- osel is sampled every clock, with no latching; mid-frame changes take effect on the next pixel.
- Pin mapping:
  - uo_out[0]=R1, [1]=G1, [2]=B1, [3]=vsync
  - uo_out[4]=R0, [5]=G0, [6]=B0, [7]=hsync
- Reset asserted mid-frame: all state returns to reset values immediately. The first frame after release starts at (0,0) with frame_cnt = 0.

Optional Feature:
- Macro: VGA_SCROLL_EN.
- Defined, with scroll=1: x = h + {frame_cnt, 2'b00} (mod 2^CNT_W) for osel 1 and 2, so bars and checkerboard scroll 4 px/frame. Blanking and sync still use raw h. scroll=0 behaves as undefined.
- Undefined: the scroll port is present but ignored; no adder is synthesised.

Test Plan (small timing: H_VIS=16, H_FP=2, H_SYNC=3, H_BP=3 (H_TOTAL=24); V_VIS=8, V_FP=1, V_SYNC=2, V_BP=1 (V_TOTAL=12); CNT_W=6):
1. Reset then release, ena=1 -> uo_out = 8'h88 during reset. hsync low exactly for uo_out cycles with h = 18..20, repeating every 24 clocks. vsync low for lines 9..10. frame_start period = 288 clocks.
2. osel=0, color=6'b110000 -> visible pixels give uo_out[0]=1, [4]=1, other colour bits 0; h >= 16 gives all colour bits 0.
3. osel=0, change color to 6'b000011 at v=3 -> current frame keeps the old colour; next frame (after frame_start) shows B1=B0=1.
4. osel=3, run 5 full frames -> frame_cnt = 5; visible rgb = 6'b000101. Run 256 frames total -> frame_cnt wraps to 0.
5. osel=2, color=6'b111111 -> pixel (0,0) rgb = 000000, pixel (8,0) = 111111, pixel (8,8) blanked (v >= V_VIS); with V_VIS raised to 16, pixel (8,8) = 000000.
6. ena=0 for 10 clocks mid-line, then rst_n low mid-frame -> all outputs frozen while ena=0; on reset, h=v=0 and uo_out = 8'h88. With VGA_SCROLL_EN, osel=1, scroll=1, frame 1 -> pixel h=0 shows rgb = 000000 (x=4); frame 4 -> rgb = 000001 (x=16).

Source files
------------

// File: rtl/vga_pattern_gen.sv
// -----------------------------------------------------------------------------
// vga_pattern_gen
//
// Parametrised VGA timing and test-pattern generator for TT tiles. Produces
// horizontal/vertical counters, sync pulses with configurable polarity, and one
// of four test patterns, driven straight onto the Tiny VGA PMOD pinout.
//
// Optional feature: define VGA_SCROLL_EN to let the scroll input shift the
// bar and checkerboard patterns by 4 pixels per frame. Without the macro the
// scroll port is present but ignored, and no adder is built.
//
// Ports:
//   clk         in   1      pixel clock
//   rst_n       in   1      asynchronous active-low reset
//   ena         in   1      tile enable; 0 freezes all state and outputs
//   osel        in   2      pattern select (0 solid, 1 bars, 2 checker, 3 flash)
//   color       in   6      RrGgBb colour for patterns 0/2, latched per frame
//   scroll      in   1      scroll request (VGA_SCROLL_EN builds only)
//   uo_out      out  8      {hsync,B0,G0,R0,vsync,B1,G1,R1}, lags h/v by 1 clk
//   h_pos       out  CNT_W  current horizontal counter
//   v_pos       out  CNT_W  current vertical counter
//   frame_start out  1      high while uo_out shows pixel (0,0)
//   frame_cnt   out  8      frames completed, wraps 255->0
// -----------------------------------------------------------------------------
module vga_pattern_gen #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int H_POL  = 0,
  parameter int V_POL  = 0,
  parameter int CNT_W  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [1:0]       osel,
  input  logic [5:0]       color,
  input  logic             scroll,
  output logic [7:0]       uo_out,
  output logic [CNT_W-1:0] h_pos,
  output logic [CNT_W-1:0] v_pos,
  output logic             frame_start,
  output logic [7:0]       frame_cnt
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  // Boundary constants are one bit wider than the counters so that the end of
  // a sync pulse may equal the total (zero back porch) without overflowing.
  localparam logic [CNT_W:0] H_LAST = (CNT_W+1)'(H_TOTAL - 1);
  localparam logic [CNT_W:0] V_LAST = (CNT_W+1)'(V_TOTAL - 1);
  localparam logic [CNT_W:0] H_VIS_C = (CNT_W+1)'(H_VIS);
  localparam logic [CNT_W:0] V_VIS_C = (CNT_W+1)'(V_VIS);
  localparam logic [CNT_W:0] HS_BEG = (CNT_W+1)'(H_VIS + H_FP);
  localparam logic [CNT_W:0] HS_END = (CNT_W+1)'(H_VIS + H_FP + H_SYNC);
  localparam logic [CNT_W:0] VS_BEG = (CNT_W+1)'(V_VIS + V_FP);
  localparam logic [CNT_W:0] VS_END = (CNT_W+1)'(V_VIS + V_FP + V_SYNC);

  localparam logic HS_ON = (H_POL != 0);
  localparam logic VS_ON = (V_POL != 0);

  // Sync bits idle at their inactive level, colour bits at zero.
  localparam logic [7:0] UO_RESET = {~HS_ON, 3'b000, ~VS_ON, 3'b000};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] h_reg, h_next;
  logic [CNT_W-1:0] v_reg, v_next;
  logic [7:0]       frame_cnt_reg, frame_cnt_next;
  logic [5:0]       color_latch_reg, color_latch_next;
  logic [7:0]       uo_out_reg;
  logic [7:0]       uo_out_next;
  logic             frame_start_reg, frame_start_next;

  // Zero-extended copies for comparison against the widened constants.
  logic [CNT_W:0] h_ext;
  logic [CNT_W:0] v_ext;
  assign h_ext = {1'b0, h_reg};
  assign v_ext = {1'b0, v_reg};

  logic h_wrap;
  logic v_wrap;
  logic frame_end;
  assign h_wrap    = (h_ext == H_LAST);
  assign v_wrap    = (v_ext == V_LAST);
  assign frame_end = h_wrap && v_wrap;

  // ---------------------------------------------------------------------------
  // Counter and colour-latch next state
  // ---------------------------------------------------------------------------
  always_comb begin
    h_next           = h_reg;
    v_next           = v_reg;
    frame_cnt_next   = frame_cnt_reg;
    color_latch_next = color_latch_reg;

    if (h_wrap) begin
      h_next = '0;
      if (v_wrap) begin
        v_next = '0;
      end else begin
        v_next = v_reg + 1'b1;
      end
    end else begin
      h_next = h_reg + 1'b1;
    end

    // The colour is only taken on the very last pixel clock of a frame, so a
    // change arriving mid-frame can never split the picture.
    if (frame_end) begin
      frame_cnt_next   = frame_cnt_reg + 8'd1;
      color_latch_next = color;
    end
  end

  // ---------------------------------------------------------------------------
  // Pattern x coordinate (optionally scrolled)
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] x;

`ifdef VGA_SCROLL_EN
  logic [CNT_W-1:0] scroll_off;
  // Offset of 4 px per completed frame, reduced mod 2^CNT_W by truncation.
  assign scroll_off = CNT_W'({frame_cnt_reg, 2'b00});
  assign x          = scroll ? (h_reg + scroll_off) : h_reg;
`else
  assign x = h_reg;
`endif

  // Bits of x and scroll that no pattern consumes in some configurations.
  logic unused_bits;
  assign unused_bits = ^{scroll, x};

  // Vertical bars: rgb = x[9:4], with positions past the counter width reading 0.
  logic [5:0] bar_rgb;
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_bar
      if (gi + 4 < CNT_W) begin : g_used
        assign bar_rgb[gi] = x[gi+4];
      end else begin : g_zero
        assign bar_rgb[gi] = 1'b0;
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Pixel colour, blanking and sync for the current (h, v)
  // ---------------------------------------------------------------------------
  logic [5:0] rgb;
  logic       blank;
  logic       hs_act;
  logic       vs_act;
  logic       hsync_lvl;
  logic       vsync_lvl;

  assign blank  = (h_ext >= H_VIS_C) || (v_ext >= V_VIS_C);
  assign hs_act = (h_ext >= HS_BEG) && (h_ext < HS_END);
  assign vs_act = (v_ext >= VS_BEG) && (v_ext < VS_END);

  assign hsync_lvl = hs_act ? HS_ON : ~HS_ON;
  assign vsync_lvl = vs_act ? VS_ON : ~VS_ON;

  always_comb begin
    rgb = color_latch_reg;
    case (osel)
      2'd0: rgb = color_latch_reg;
      2'd1: rgb = bar_rgb;
      2'd2: rgb = (x[3] ^ v_reg[3]) ? color_latch_reg : ~color_latch_reg;
      2'd3: rgb = frame_cnt_reg[5:0];
      default: rgb = color_latch_reg;
    endcase
    // Blanking applies to colour only; sync keeps running.
    if (blank) begin
      rgb = 6'b000000;
    end
  end

  // ---------------------------------------------------------------------------
  // PMOD pin mapping: rgb = {R1,R0,G1,G0,B1,B0}
  //   uo_out[2:0] = {B1,G1,R1}, uo_out[6:4] = {B0,G0,R0}
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_pin
      assign uo_out_next[gi]     = rgb[5 - 2*gi];
      assign uo_out_next[gi + 4] = rgb[4 - 2*gi];
    end
  endgenerate
  assign uo_out_next[3] = vsync_lvl;
  assign uo_out_next[7] = hsync_lvl;

  // Registered alongside uo_out so it lines up with pixel (0,0) on the pins.
  assign frame_start_next = (h_reg == '0) && (v_reg == '0);

  // ---------------------------------------------------------------------------
  // Registers; ena=0 freezes everything, including the output registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_reg           <= '0;
      v_reg           <= '0;
      frame_cnt_reg   <= 8'd0;
      color_latch_reg <= 6'd0;
      uo_out_reg      <= UO_RESET;
      frame_start_reg <= 1'b0;
    end else if (ena) begin
      h_reg           <= h_next;
      v_reg           <= v_next;
      frame_cnt_reg   <= frame_cnt_next;
      color_latch_reg <= color_latch_next;
      uo_out_reg      <= uo_out_next;
      frame_start_reg <= frame_start_next;
    end
  end

  assign uo_out      = uo_out_reg;
  assign h_pos       = h_reg;
  assign v_pos       = v_reg;
  assign frame_start = frame_start_reg;
  assign frame_cnt   = frame_cnt_reg;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_pattern_gen
//
// Randomised bench for vga_pattern_gen using a small 24x12 timing. The
// reference model derives (h, v, frame) from the number of enabled clocks since
// reset using division/modulo, and computes the expected pin image pixel by
// pixel from the pattern rules. Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_vga_pattern_gen;

  localparam int HV = 16, HFP = 2, HS = 3, HBP = 3;
  localparam int VV = 8,  VFP = 1, VS = 2, VBP = 1;
  localparam int HT = HV + HFP + HS + HBP;   // 24
  localparam int VT = VV + VFP + VS + VBP;   // 12
  localparam int FRAME = HT * VT;            // 288
  localparam int CW = 6;

`ifdef VGA_SCROLL_EN
  localparam bit SCROLL_ON = 1'b1;
`else
  localparam bit SCROLL_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b0;
  logic [1:0]    osel = 2'd0;
  logic [5:0]    color = 6'd0;
  logic          scroll = 1'b0;
  logic [7:0]    uo_out;
  logic [CW-1:0] h_pos;
  logic [CW-1:0] v_pos;
  logic          frame_start;
  logic [7:0]    frame_cnt;

  vga_pattern_gen #(
    .H_VIS(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_VIS(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .H_POL(0), .V_POL(0), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .osel(osel),
    .color(color),
    .scroll(scroll),
    .uo_out(uo_out),
    .h_pos(h_pos),
    .v_pos(v_pos),
    .frame_start(frame_start),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model state
  int         m_t;       // enabled clocks since reset
  logic [5:0] m_latch;   // colour shown in the current frame
  logic [7:0] m_uo;
  logic       m_fs;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Expected pin image for pixel (h, v) from the pattern rules.
  function automatic logic [7:0] pixel(input int h, input int v, input int os,
                                       input logic [5:0] lat, input int fc, input bit scr);
    int         x;
    logic [5:0] rgb;
    bit         hs_n, vs_n;
    x = (h + ((SCROLL_ON && scr) ? 4 * fc : 0)) % 64;
    case (os)
      0:       rgb = lat;
      1:       rgb = 6'(x / 16);
      2:       rgb = (((x / 8) % 2) != ((v / 8) % 2)) ? lat : ~lat;
      default: rgb = 6'(fc % 64);
    endcase
    if (h >= HV || v >= VV) rgb = 6'd0;
    hs_n = !(h >= HV + HFP && h < HV + HFP + HS);
    vs_n = !(v >= VV + VFP && v < VV + VFP + VS);
    return {hs_n, rgb[0], rgb[2], rgb[4], vs_n, rgb[1], rgb[3], rgb[5]};
  endfunction

  task automatic model_reset();
    m_t     = 0;
    m_latch = 6'd0;
    m_uo    = 8'h88;
    m_fs    = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_update();
    int h, v, fc;
    if (rst_n && ena) begin
      h    = m_t % HT;
      v    = (m_t / HT) % VT;
      fc   = (m_t / FRAME) % 256;
      m_uo = pixel(h, v, osel, m_latch, fc, scroll);
      m_fs = (h == 0) && (v == 0);
      if (h == HT - 1 && v == VT - 1) m_latch = color;
      m_t++;
    end
  endtask

  task automatic compare_all();
    check_val("uo_out", uo_out, m_uo);
    check_val("h_pos", h_pos, m_t % HT);
    check_val("v_pos", v_pos, (m_t / HT) % VT);
    check_val("frame_cnt", frame_cnt, (m_t / FRAME) % 256);
    check_val("frame_start", frame_start, m_fs);
    if (m_t == 5 * FRAME)   check_val("frame_cnt_5", frame_cnt, 5);
    if (m_t == 256 * FRAME) check_val("frame_cnt_wrap", frame_cnt, 0);
  endtask

  task automatic check_reset_state();
    check_val("rst_uo_out", uo_out, 8'h88);
    check_val("rst_h_pos", h_pos, 0);
    check_val("rst_v_pos", v_pos, 0);
    check_val("rst_frame_cnt", frame_cnt, 0);
    check_val("rst_frame_start", frame_start, 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic randomize_inputs(input bit allow_idle);
    ena = allow_idle ? (($urandom % 8) != 0) : 1'b1;
    if (($urandom % 16) == 0) osel = 2'($urandom % 4);
    if (($urandom % 32) == 0) color = 6'($urandom % 64);
    if (($urandom % 64) == 0) scroll = ~scroll;
  endtask

  initial begin
    int guard;
    model_reset();
    #12;
    check_reset_state();
    @(negedge clk);
    rst_n = 1'b1;
    ena   = 1'b1;
    osel  = 2'd0;
    color = 6'b110000;

    // Phase A: random enable, pattern, colour and scroll; reset mid-frame.
    for (int i = 0; i < 3000; i++) begin
      step();
      if (i == 1500) begin
        rst_n = 1'b0;
        #1;
        check_reset_state();
        model_reset();
        @(negedge clk);
        check_reset_state();
        rst_n = 1'b1;
      end
      if (i >= 700 && i < 710) ena = 1'b0;
      else randomize_inputs(1'b1);
    end

    // Phase B: enabled run long enough to see frame_cnt wrap past 255.
    guard = 0;
    while (m_t < 256 * FRAME + 30 && guard < 80000) begin
      step();
      randomize_inputs(1'b0);
      guard++;
    end
    if (guard >= 80000) check_val("phase_b_timeout", guard, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
